// File: rtl/multi_fifo_reduce_adder_pkg.sv
// rtl/multi_fifo_reduce_adder_pkg.sv - shared constants and width helper for the reduce adder
package multi_fifo_reduce_adder_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Width needed to hold the exact sum of n_in operands of the given width.
  function automatic int sum_width(input int width, input int n_in);
    return width + $clog2(n_in);
  endfunction

endpackage

// File: rtl/ff_fifo_cnt.sv
// rtl/ff_fifo_cnt.sv - flip-flop FIFO with occupancy count, any depth >= 2
module ff_fifo_cnt #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign read_data = mem[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= write_data;
  end

endmodule

// File: rtl/multi_fifo_reduce_adder.sv
// rtl/multi_fifo_reduce_adder.sv - N input FIFOs reduced by a registered adder into a result FIFO
module multi_fifo_reduce_adder
  import multi_fifo_reduce_adder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 5,
  parameter int N_IN     = 3,
  parameter int SATURATE = SAT_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [N_IN-1:0]       can_push,
  input  logic [N_IN-1:0]       push,
  input  logic [N_IN*WIDTH-1:0] data_in,
  output logic                  can_pop_sum,
  input  logic                  pop_sum,
  output logic [WIDTH-1:0]      sum,
  output logic                  sum_ovf
);

  localparam int SUM_W = sum_width(WIDTH, N_IN);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [N_IN-1:0]  in_empty;
  logic [N_IN-1:0]  in_full;
  logic [WIDTH-1:0] operand [N_IN];
  logic [CNT_W-1:0] unused_in_count [N_IN];
  logic             fire;

  logic [SUM_W-1:0] full_sum;
  logic             ovf;
  logic [WIDTH-1:0] stored;

  logic             stage_valid;
  logic [WIDTH-1:0] stage_sum;
  logic             stage_ovf;

  logic [CNT_W-1:0] count_sum;
  logic             sum_empty;
  logic             unused_sum_full;
  logic [WIDTH:0]   head;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    ff_fifo_cnt #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[i]),
      .pop        (fire),
      .write_data (data_in[i*WIDTH +: WIDTH]),
      .read_data  (operand[i]),
      .empty      (in_empty[i]),
      .full       (in_full[i]),
      .count      (unused_in_count[i])
    );
  end

  assign can_push = ~in_full;

  // Credit counts the result already in the stage; a same-cycle pop earns none.
  assign fire = (&(~in_empty)) && ((int'(count_sum) + int'(stage_valid)) < DEPTH);

  always_comb begin
    full_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      full_sum = full_sum + SUM_W'(operand[i]);
    end
  end

  assign ovf    = |full_sum[SUM_W-1:WIDTH];
  assign stored = (SATURATE == SAT_CLAMP && ovf) ? '1 : full_sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= fire;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      stage_sum <= stored;
      stage_ovf <= ovf;
    end
  end

  ff_fifo_cnt #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_sum_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (stage_valid),
    .pop        (pop_sum),
    .write_data ({stage_ovf, stage_sum}),
    .read_data  (head),
    .empty      (sum_empty),
    .full       (unused_sum_full),
    .count      (count_sum)
  );

  assign can_pop_sum = ~sum_empty;
  assign sum         = head[WIDTH-1:0];
  assign sum_ovf     = head[WIDTH];

endmodule
